// File: rtl/spi_reg_bank_if.sv
// Byte-level link between spi_slave and spi_reg_bank in the clk_core domain.
interface spi_reg_bank_if;
  logic       transaction_begin;
  logic       rx_byte_available;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (
    output transaction_begin,
    output rx_byte_available,
    output rx_byte,
    input  tx_byte
  );

  modport slave (
    input  transaction_begin,
    input  rx_byte_available,
    input  rx_byte,
    output tx_byte
  );
endinterface

// File: rtl/spi_reg_bank.sv
// Host-visible register bank behind the SPI slave: command byte, auto-incrementing
// data burst, and the next transmit byte for spi_slave to shift out.
module spi_reg_bank #(
  parameter logic [7:0] FPGA_VER = 8'hC2
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_reg_bank_if.slave  bus,
  output logic           bootloader_force
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  localparam logic [6:0] ADDR_VERSION = 7'h00;
  localparam logic [6:0] ADDR_CONTROL = 7'h01;
  localparam logic [6:0] ADDR_SCRATCH = 7'h02;
  localparam logic [6:0] ADDR_XFER    = 7'h03;
  localparam logic [6:0] ADDR_ERR     = 7'h04;

  state_t     r_state, w_state_nxt;
  logic       r_avail_sync;
  logic [1:0] r_s;
  logic       r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_tx;
  logic       r_boot;
  logic [7:0] r_scratch, r_xfer_cnt, r_err_cnt;

  logic       w_byte_evt, w_cmd_evt, w_data_evt;
  logic       w_rd_evt, w_wr_evt, w_err_inc;
  logic [6:0] w_addr_inc, w_rd_addr;
  logic [7:0] w_rd_data;

  // History s sits one flop behind the input sampler, so the edge term is
  // true one cycle after the first high sample and updates land two edges later.
  assign w_byte_evt = (r_s == 2'b01);
  assign w_addr_inc = r_addr + 7'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_evt   = 1'b0;
    w_data_evt  = 1'b0;
    if (bus.transaction_begin) begin
      w_state_nxt = ST_CMD;
    end else if (w_byte_evt) begin
      case (r_state)
        ST_CMD: begin
          w_cmd_evt   = 1'b1;
          w_state_nxt = ST_DATA;
        end
        ST_DATA: w_data_evt = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_addr = w_cmd_evt ? bus.rx_byte[6:0] : w_addr_inc;
    w_rd_evt  = (w_cmd_evt && !bus.rx_byte[7]) || (w_data_evt && !r_rw);
    w_wr_evt  = w_data_evt && r_rw;
    case (w_rd_addr)
      ADDR_VERSION: w_rd_data = FPGA_VER;
      ADDR_CONTROL: w_rd_data = {7'd0, r_boot};
      ADDR_SCRATCH: w_rd_data = r_scratch;
      ADDR_XFER:    w_rd_data = r_xfer_cnt;
      ADDR_ERR:     w_rd_data = r_err_cnt;
      default:      w_rd_data = 8'h00;
    endcase
    w_err_inc = (w_rd_evt && (w_rd_addr > ADDR_ERR)) ||
                (w_wr_evt && (r_addr > ADDR_ERR));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_avail_sync <= 1'b0;
      r_s          <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_avail_sync <= bus.rx_byte_available;
      r_s          <= {r_s[0], r_avail_sync};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rw       <= 1'b0;
      r_addr     <= 7'd0;
      r_tx       <= 8'h00;
      r_boot     <= 1'b0;
      r_scratch  <= 8'h00;
      r_xfer_cnt <= 8'h00;
      r_err_cnt  <= 8'h00;
    end else begin
      if (bus.transaction_begin) begin
        r_tx       <= 8'h00;
        r_xfer_cnt <= r_xfer_cnt + 8'd1;
      end
      if (w_cmd_evt) begin
        r_rw   <= bus.rx_byte[7];
        r_addr <= bus.rx_byte[6:0];
      end
      if (w_data_evt) r_addr <= w_addr_inc;
      if (w_rd_evt)   r_tx   <= w_rd_data;
      if (w_wr_evt) begin
        case (r_addr)
          ADDR_CONTROL: r_boot    <= bus.rx_byte[0];
          ADDR_SCRATCH: r_scratch <= bus.rx_byte;
          ADDR_ERR:     r_err_cnt <= 8'h00;
          default: ;
        endcase
      end
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.tx_byte      = r_tx;
  assign bootloader_force = r_boot;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: scenario tasks with a queue scoreboard
// of expected tx_byte values, observing only the bank's outputs.
module tb_spi_reg_bank;

  logic clk = 1'b0;
  logic reset_n;
  logic bootloader_force;

  always #10 clk = ~clk;

  spi_reg_bank_if bus ();

  spi_reg_bank #(.FPGA_VER(8'hC2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .bootloader_force (bootloader_force)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_xfer = 8'h00;

  task automatic do_begin();
    @(negedge clk);
    bus.transaction_begin = 1'b1;
    @(negedge clk);
    bus.transaction_begin = 1'b0;
    exp_xfer = exp_xfer + 8'd1;
  endtask

  task automatic drop_strobe();
    @(negedge clk);
    bus.rx_byte_available = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One byte slot: strobe rises, result is due three clock edges later.
  task automatic send_byte(input logic [7:0] b, input bit chk,
                           input logic [7:0] exp, input string name);
    logic [7:0] e;
    @(negedge clk);
    bus.rx_byte           = b;
    bus.rx_byte_available = 1'b1;
    if (chk) exp_q.push_back(exp);
    repeat (3) @(posedge clk);
    #1;
    if (chk) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.tx_byte !== e) begin
        errors++;
        $display("FAIL %s: tx_byte got %02h expected %02h", name, bus.tx_byte, e);
      end
    end
    drop_strobe();
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset_n               = 1'b0;
    bus.transaction_begin = 1'b0;
    bus.rx_byte_available = 1'b0;
    bus.rx_byte           = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.tx_byte !== 8'h00 || bootloader_force !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%02h bf=%b expected 00/0", bus.tx_byte, bootloader_force);
    end
    reset_n = 1'b1;
    send_byte(8'h81, 1, 8'h00, "idle_cmd_ignored");
    send_byte(8'h01, 1, 8'h00, "idle_data_ignored");
    checks++;
    if (bootloader_force !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_write: bf got %b expected 0", bootloader_force);
    end
    do_begin();
    @(negedge clk);
    bus.rx_byte           = 8'h00;
    bus.rx_byte_available = 1'b1;
    exp_q.push_back(8'hC2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL latency_early: tx_byte got %02h expected 00", bus.tx_byte);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (bus.tx_byte !== e) begin
      errors++;
      $display("FAIL latency_version: tx_byte got %02h expected %02h", bus.tx_byte, e);
    end
    drop_strobe();
    send_byte(8'h00, 1, 8'h00,    "rd_control_rst");
    send_byte(8'h00, 1, 8'h00,    "rd_scratch_rst");
    send_byte(8'h00, 1, exp_xfer, "rd_xfer_one");
    send_byte(8'h00, 1, 8'h00,    "rd_err_rst");
  endtask

  task automatic test_burst_write();
    do_begin();
    send_byte(8'h81, 1, 8'h00, "wr_cmd_tx");
    send_byte(8'h01, 1, 8'h00, "wr_control_tx");
    send_byte(8'h5A, 1, 8'h00, "wr_scratch_tx");
    checks++;
    if (bootloader_force !== 1'b1) begin
      errors++;
      $display("FAIL bf_set: bf got %b expected 1", bootloader_force);
    end
    do_begin();
    send_byte(8'h01, 1, 8'h01,    "rd_control");
    send_byte(8'hEE, 1, 8'h5A,    "rd_scratch");
    send_byte(8'h33, 1, exp_xfer, "rd_xfer");
  endtask

  task automatic test_unmapped();
    do_begin();
    send_byte(8'h85, 1, 8'h00, "unm_cmd");
    send_byte(8'hAA, 1, 8'h00, "unm_wr1");
    send_byte(8'hBB, 1, 8'h00, "unm_wr2");
    do_begin();
    send_byte(8'h04, 1, 8'h02, "err_two");
    send_byte(8'h00, 1, 8'h00, "unm_read_zero");
    do_begin();
    send_byte(8'h02, 1, 8'h5A,    "scratch_kept");
    send_byte(8'h00, 1, exp_xfer, "xfer_after_unm");
    send_byte(8'h00, 1, 8'h03,    "err_after_unm_read");
    checks++;
    if (bootloader_force !== 1'b1) begin
      errors++;
      $display("FAIL bf_kept: bf got %b expected 1", bootloader_force);
    end
    do_begin();
    send_byte(8'h84, 0, 8'h00, "");
    send_byte(8'h00, 0, 8'h00, "");
    do_begin();
    send_byte(8'h04, 1, 8'h00, "err_cleared");
  endtask

  task automatic test_saturate();
    for (int t = 0; t < 3; t++) begin
      do_begin();
      send_byte(8'h85, 0, 8'h00, "");
      for (int i = 0; i < 100; i++) send_byte(i[7:0], 0, 8'h00, "");
    end
    do_begin();
    send_byte(8'h04, 1, 8'hFF, "err_saturated");
    send_byte(8'h00, 1, 8'h00, "unm_read_at_sat");
    do_begin();
    send_byte(8'h04, 1, 8'hFF, "err_stays_ff");
    do_begin();
    send_byte(8'h84, 0, 8'h00, "");
    send_byte(8'h00, 0, 8'h00, "");
  endtask

  task automatic test_wrap();
    do_begin();
    send_byte(8'hFF, 1, 8'h00, "wrap_cmd");
    send_byte(8'h11, 1, 8'h00, "wrap_wr7f");
    send_byte(8'h22, 1, 8'h00, "wrap_wr00");
    do_begin();
    send_byte(8'h00, 1, 8'hC2,    "wrap_version");
    send_byte(8'h00, 1, 8'h01,    "wrap_control");
    send_byte(8'h00, 1, 8'h5A,    "wrap_scratch");
    send_byte(8'h00, 1, exp_xfer, "wrap_xfer");
    send_byte(8'h00, 1, 8'h01,    "wrap_err_one");
  endtask

  task automatic test_abort();
    do_begin();
    send_byte(8'h82, 1, 8'h00, "abort_wr_cmd");
    do_begin();
    send_byte(8'h02, 1, 8'h5A,    "abort_as_read");
    send_byte(8'h00, 1, exp_xfer, "abort_next");
  endtask

  task automatic test_collision();
    do_begin();
    send_byte(8'h00, 1, 8'hC2, "coll_pre");
    @(negedge clk);
    bus.rx_byte           = 8'h00;
    bus.rx_byte_available = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.transaction_begin = 1'b1;
    exp_xfer = exp_xfer + 8'd1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL coll_dropped: tx_byte got %02h expected 00", bus.tx_byte);
    end
    @(negedge clk);
    bus.transaction_begin = 1'b0;
    drop_strobe();
    send_byte(8'h02, 1, 8'h5A,    "coll_state_cmd");
    send_byte(8'h00, 1, exp_xfer, "coll_xfer");
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    do_begin();
    send_byte(8'h02, 1, 8'h5A, "hold_first");
    @(negedge clk);
    bus.rx_byte           = 8'h00;
    bus.rx_byte_available = 1'b1;
    exp_q.push_back(exp_xfer);
    repeat (12) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (bus.tx_byte !== e) begin
      errors++;
      $display("FAIL hold_single_event: tx_byte got %02h expected %02h", bus.tx_byte, e);
    end
    drop_strobe();
    send_byte(8'h00, 1, 8'h01, "hold_next_err");
  endtask

  task automatic test_async_reset();
    do_begin();
    send_byte(8'h81, 1, 8'h00, "mid_cmd");
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (bootloader_force !== 1'b0 || bus.tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: bf=%b tx=%02h expected 0/00", bootloader_force, bus.tx_byte);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    exp_xfer = 8'h00;
    send_byte(8'h81, 1, 8'h00, "post_rst_cmd");
    send_byte(8'h01, 1, 8'h00, "post_rst_data");
    checks++;
    if (bootloader_force !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: bf got %b expected 0", bootloader_force);
    end
    do_begin();
    send_byte(8'h02, 1, 8'h00,    "post_rst_scratch");
    send_byte(8'h00, 1, exp_xfer, "post_rst_xfer");
    send_byte(8'h00, 1, 8'h00,    "post_rst_err");
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_unmapped();
    test_saturate();
    test_wrap();
    test_abort();
    test_collision();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
